// File: rtl/ones_word_gen.sv
// rtl/ones_word_gen.sv - emits every contiguous-ones word for a requested ones-count
//
// Purpose: given a ones-count, streams the thermometer code of that count and
// each of its left rotations over a valid/ready handshake. Intended to drive a
// popcount unit in closed loop: popcount(a_out) equals the loaded count.
//
// Ports:
//   clk     system clock, all state changes on posedge
//   rst_n   asynchronous active-low reset
//   load    start request, sampled only while idle
//   cnt_in  requested ones-count (saturated to WIDTH)
//   ready   downstream accepts a_out this cycle
//   valid   a_out holds a word
//   a_out   generated word
//   busy    high while a sequence is being emitted
//   done    one-cycle pulse after the last word transfers
//   err     last accepted load requested more than WIDTH ones
module ones_word_gen #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CW-1:0]    cnt_in,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] a_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int RW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state_q;
  logic [RW-1:0]    rot_q;
  logic [CW-1:0]    n_q;
  logic             valid_q;
  logic [WIDTH-1:0] a_out_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  // Built one bit wider so that n == WIDTH yields all ones.
  function automatic logic [WIDTH-1:0] therm(input logic [CW-1:0] n);
    logic [WIDTH:0] t;
    t = (WIDTH+1)'(1) << n;
    t = t - (WIDTH+1)'(1);
    return t[WIDTH-1:0];
  endfunction

  // Rotate left: shifting a doubled copy moves the MSBs around into the LSBs.
  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x,
                                            input logic [RW-1:0]    r);
    logic [2*WIDTH-1:0] d;
    d = {x, x} << r;
    return d[2*WIDTH-1:WIDTH];
  endfunction

  logic [CW-1:0] n_load_d;
  logic          err_load_d;
  logic [RW-1:0] rot_d;
  logic          last_word;
  logic          xfer;

  assign err_load_d = (cnt_in > CW'(WIDTH));
  assign n_load_d   = err_load_d ? CW'(WIDTH) : cnt_in;
  assign rot_d      = rot_q + RW'(1);
  // All rotations of 0x00 / all-ones are identical, so those emit one word.
  assign last_word  = (n_q == '0) || (n_q == CW'(WIDTH)) || (rot_q == RW'(WIDTH-1));
  assign xfer       = valid_q & ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rot_q   <= '0;
      n_q     <= '0;
      valid_q <= 1'b0;
      a_out_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load) begin
            n_q     <= n_load_d;
            err_q   <= err_load_d;
            rot_q   <= '0;
            state_q <= EMIT;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            a_out_q <= therm(n_load_d);
          end
        end
        EMIT: begin
          if (xfer) begin
            if (last_word) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              a_out_q <= '0;
              done_q  <= 1'b1;
            end else begin
              rot_q   <= rot_d;
              a_out_q <= rotl(therm(n_q), rot_d);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign valid = valid_q;
  assign a_out = a_out_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_ones_word_gen.sv
// tb/tb_ones_word_gen.sv - scoreboard bench for ones_word_gen
module tb_ones_word_gen;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [3:0] cnt_in;
  logic       ready;
  logic       valid;
  logic [7:0] a_out;
  logic       busy;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_n    = 0;

  logic [7:0] exp_q[$];

  ones_word_gen #(.WIDTH(8), .CW(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .cnt_in (cnt_in),
    .ready  (ready),
    .valid  (valid),
    .a_out  (a_out),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit i is set when it lies within n positions above the rotation offset.
  function automatic logic [7:0] model_word(input int n, input int r);
    logic [7:0] w;
    for (int i = 0; i < 8; i++) w[i] = (((i - r + 8) % 8) < n);
    return w;
  endfunction

  task automatic push_seq(input int cnt);
    int nw;
    exp_n = (cnt > 8) ? 8 : cnt;
    nw = (exp_n == 0 || exp_n == 8) ? 1 : 8;
    for (int r = 0; r < nw; r++) exp_q.push_back(model_word(exp_n, r));
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0,1,0,0...
  // ign: hold load high with cnt_in=1 during EMIT. stop>0: return after that many transfers.
  task automatic run(input int cnt, input int mode, input bit ign, input int stop, input string tag);
    int k = 0;
    int xfers = 0;
    bit got_done = 0;
    bit have_held = 0;
    logic [7:0] held = '0;
    push_seq(cnt);
    ready = 1'b1;
    @(posedge clk); #1;
    load = 1'b1;
    cnt_in = cnt[3:0];
    @(posedge clk); #1;
    if (ign) cnt_in = 4'd1;
    else load = 1'b0;
    check({tag, " latency valid"}, valid, 1);
    check({tag, " latency busy"}, busy, 1);
    for (int cyc = 0; cyc < 64 && !got_done; cyc++) begin
      @(negedge clk);
      if (have_held && valid) check({tag, " stall hold"}, a_out, held);
      have_held = 0;
      if (valid) begin
        check({tag, " popcount"}, $countones(a_out), exp_n);
        if (ready) begin
          if (exp_q.size() == 0) check({tag, " extra word"}, a_out, 32'hdead);
          else check({tag, " word"}, a_out, exp_q.pop_front());
          xfers++;
          if (ign && exp_q.size() == 0) load = 1'b0;
        end else begin
          held = a_out;
          have_held = 1;
        end
      end
      if (done) begin
        got_done = 1;
        check({tag, " words left at done"}, exp_q.size(), 0);
        check({tag, " valid at done"}, valid, 0);
        check({tag, " busy at done"}, busy, 0);
      end
      @(posedge clk); #1;
      k++;
      ready = (mode == 0) ? 1'b1 : (k % 3 == 0);
      if (stop > 0 && xfers == stop) return;
    end
    if (!got_done) check({tag, " done timeout"}, 0, 1);
    check({tag, " done one cycle"}, done, 0);
    check({tag, " idle after done"}, valid, 0);
    check({tag, " err"}, err, (cnt > 8) ? 1 : 0);
  endtask

  initial begin
    rst_n  = 1'b0;
    load   = 1'b0;
    cnt_in = 4'd0;
    ready  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst valid", valid, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst err", err, 0);
    check("rst a_out", a_out, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run(3, 0, 0, 0, "cnt3");
    run(0, 0, 0, 0, "cnt0");
    run(8, 0, 0, 0, "cnt8");
    run(12, 0, 0, 0, "cnt12");
    run(5, 0, 0, 0, "cnt5");
    run(2, 1, 0, 0, "cnt2 stall");
    run(4, 0, 1, 0, "cnt4 load ignored");

    run(12, 0, 0, 0, "cnt12 pre-reset");
    run(6, 0, 0, 3, "cnt6 partial");
    rst_n = 1'b0;
    #1;
    check("midrst valid", valid, 0);
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst err", err, 0);
    check("midrst a_out", a_out, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no done after reset", done, 0);
      check("idle after reset", valid, 0);
    end
    run(1, 0, 0, 0, "cnt1 after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
